stream_demux: RTL and testbench

- 1-to-2 demultiplexer with valid/ready handshaking. It steers each accepted input beat to output port 0 or 1 according to the select bit sampled with that beat.
- Counterpart to the datapath 2:1 multiplexer. It is used where one producer (e.g. the memory response path) feeds two consumers, such as instruction fetch and load/store.
- Each output has its own small FIFO, so a stalled consumer does not block beats queued for the other.

---
 rtl/stream_demux_pkg.sv | 14 +
 rtl/stream_demux_if.sv | 34 +++
 rtl/stream_demux_fifo.sv | 62 ++++++
 rtl/stream_demux.sv | 59 +++++
 tb/tb_stream_demux.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_demux_pkg.sv
// Shared types and default sizing for the 1-to-2 stream demultiplexer.
package stream_demux_pkg;

    typedef enum logic {
        DEST0 = 1'b0,
        DEST1 = 1'b1
    } dest_e;

    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 2;
    // Occupancy needs one extra bit so that a full FIFO (count == DEPTH) is representable.
    localparam int CNT_W_DEF = $clog2(DEPTH_DEF) + 1;

endpackage

// File: rtl/stream_demux_if.sv
// Handshake bundle between a single producer, the demux and its two consumers.
interface stream_demux_if
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] d;
    logic             s;
    logic             d_valid;
    logic             d_ready;
    logic [WIDTH-1:0] y0;
    logic             y0_valid;
    logic             y0_ready;
    logic [WIDTH-1:0] y1;
    logic             y1_valid;
    logic             y1_ready;
    logic [CW-1:0]    count0;
    logic [CW-1:0]    count1;

    // master: producer plus both consumers; slave: the demux itself
    modport master (
        output d, s, d_valid, y0_ready, y1_ready,
        input  d_ready, y0, y0_valid, y1, y1_valid, count0, count1
    );

    modport slave (
        input  d, s, d_valid, y0_ready, y1_ready,
        output d_ready, y0, y0_valid, y1, y1_valid, count0, count1
    );

endinterface

// File: rtl/stream_demux_fifo.sv
// Small show-ahead FIFO: the head entry is presented on rdata as soon as it is written.
module demux_fifo
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    output logic                       full,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign rdata   = mem[rd_ptr_reg];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage is data-only; validity is tracked entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/stream_demux.sv
// 1-to-2 stream demultiplexer: each accepted beat is queued in the FIFO chosen by s.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    stream_demux_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    dest_e            dest;
    logic             d_ready;
    logic [1:0]       push;
    logic [1:0]       pop;
    logic [1:0]       full;
    logic [1:0]       empty;
    logic [1:0]       out_ready;
    logic [WIDTH-1:0] rdata [2];
    logic [CW-1:0]    count [2];

    assign dest      = dest_e'(bus.s);
    assign out_ready = {bus.y1_ready, bus.y0_ready};

    // Input ready looks only at the selected FIFO's registered full flag, so
    // consumer ready never reaches producer ready combinationally.
    assign d_ready     = reset_n && ((dest == DEST1) ? !full[1] : !full[0]);
    assign bus.d_ready = d_ready;

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        assign push[gi] = bus.d_valid && d_ready && (dest == ((gi == 1) ? DEST1 : DEST0));
        assign pop[gi]  = out_ready[gi] && !empty[gi];

        demux_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .reset_n (reset_n),
            .push    (push[gi]),
            .wdata   (bus.d),
            .full    (full[gi]),
            .pop     (pop[gi]),
            .rdata   (rdata[gi]),
            .empty   (empty[gi]),
            .count   (count[gi])
        );
    end

    assign bus.y0       = rdata[0];
    assign bus.y0_valid = !empty[0];
    assign bus.count0   = count[0];
    assign bus.y1       = rdata[1];
    assign bus.y1_valid = !empty[1];
    assign bus.count1   = count[1];

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: routing, backpressure, concurrency, wrap and reset.
module tb_stream_demux;
    import stream_demux_pkg::*;

    localparam int W  = 8;
    localparam int DP = 2;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    logic [W-1:0] rx0[$];
    logic [W-1:0] rx1[$];

    stream_demux_if #(.WIDTH(W), .DEPTH(DP)) bus ();

    stream_demux #(.WIDTH(W), .DEPTH(DP)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Output handshakes are sampled mid-cycle; inputs only change just after rising edges.
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.y0_valid && bus.y0_ready) rx0.push_back(bus.y0);
            if (bus.y1_valid && bus.y1_ready) rx1.push_back(bus.y1);
        end
        checks++;
        if (bus.count0 > CNT_W_DEF'(DP) || bus.count1 > CNT_W_DEF'(DP)) begin
            errors++;
            $display("FAIL count_bound: count0=%0d count1=%0d limit=%0d", bus.count0, bus.count1, DP);
        end
        checks++;
        if (bus.y0_valid !== (bus.count0 != 0) || bus.y1_valid !== (bus.count1 != 0)) begin
            errors++;
            $display("FAIL valid_vs_count: y0_valid=%b count0=%0d y1_valid=%b count1=%0d",
                     bus.y0_valid, bus.count0, bus.y1_valid, bus.count1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until it is accepted; called just after a rising edge.
    task automatic send(input logic [W-1:0] data, input logic sel);
        bit done = 0;
        bus.d       = data;
        bus.s       = sel;
        bus.d_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (bus.d_ready) begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        bus.d_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL send_timeout: beat %h s=%b not accepted, required acceptance within 50 cycles", data, sel);
        end
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        bus.d        = '0;
        bus.s        = 1'b0;
        bus.d_valid  = 1'b0;
        bus.y0_ready = 1'b0;
        bus.y1_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.d_ready !== 1'b0) begin errors++; $display("FAIL reset_d_ready: got %b want 0", bus.d_ready); end
        checks++;
        if (bus.y0_valid !== 1'b0 || bus.y1_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valids: got %b%b want 00", bus.y1_valid, bus.y0_valid);
        end
        checks++;
        if (bus.count0 !== '0 || bus.count1 !== '0) begin
            errors++; $display("FAIL reset_counts: got %0d/%0d want 0/0", bus.count0, bus.count1);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();
        checks++;
        if (bus.d_ready !== 1'b1) begin errors++; $display("FAIL release_d_ready: got %b want 1", bus.d_ready); end
        $display("test_reset: done");
    endtask

    task automatic test_basic_routing();
        rx0.delete();
        rx1.delete();
        bus.y0_ready = 1'b1;
        bus.y1_ready = 1'b1;
        send(8'hA5, 1'b0);
        checks++;
        if (bus.y0_valid !== 1'b1 || bus.y0 !== 8'hA5) begin
            errors++; $display("FAIL basic_y0: got valid=%b y0=%h want 1/a5", bus.y0_valid, bus.y0);
        end
        checks++;
        if (bus.y1_valid !== 1'b0) begin errors++; $display("FAIL basic_y1_idle: got y1_valid=%b want 0", bus.y1_valid); end
        send(8'h3C, 1'b1);
        checks++;
        if (bus.y1_valid !== 1'b1 || bus.y1 !== 8'h3C) begin
            errors++; $display("FAIL basic_y1: got valid=%b y1=%h want 1/3c", bus.y1_valid, bus.y1);
        end
        tick();
        checks++;
        if (bus.count0 !== '0 || bus.count1 !== '0) begin
            errors++; $display("FAIL basic_drain: got counts %0d/%0d want 0/0", bus.count0, bus.count1);
        end
        checks++;
        if (rx0.size() != 1 || rx1.size() != 1 || rx0[0] !== 8'hA5 || rx1[0] !== 8'h3C) begin
            errors++; $display("FAIL basic_rx: got %0d/%0d beats want a5 on y0 and 3c on y1", rx0.size(), rx1.size());
        end
        $display("test_basic_routing: y0=%p y1=%p", rx0, rx1);
    endtask

    task automatic test_backpressure();
        logic [W-1:0] exp0 [3];
        exp0 = '{8'h01, 8'h02, 8'h03};
        rx0.delete();
        rx1.delete();
        bus.y0_ready = 1'b0;
        bus.y1_ready = 1'b1;
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        checks++;
        if (bus.count0 !== 2'd2) begin errors++; $display("FAIL bp_count0_full: got %0d want 2", bus.count0); end
        bus.d = 8'h03; bus.s = 1'b0; bus.d_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.d_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got d_ready=%b want 0", bus.d_ready); end
        tick();
        bus.d_valid = 1'b0;
        checks++;
        if (bus.count0 !== 2'd2) begin errors++; $display("FAIL bp_no_push: got count0=%0d want 2", bus.count0); end
        bus.d = 8'h04; bus.s = 1'b1; bus.d_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.d_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_other: got d_ready=%b want 1", bus.d_ready); end
        tick();
        bus.d_valid = 1'b0;
        checks++;
        if (bus.y1_valid !== 1'b1 || bus.y1 !== 8'h04) begin
            errors++; $display("FAIL bp_y1: got valid=%b y1=%h want 1/04", bus.y1_valid, bus.y1);
        end
        bus.y0_ready = 1'b1;
        send(8'h03, 1'b0);
        repeat (4) tick();
        checks++;
        if (rx0.size() != 3) begin errors++; $display("FAIL bp_rx0_len: got %0d want 3", rx0.size()); end
        for (int i = 0; i < 3 && i < rx0.size(); i++) begin
            checks++;
            if (rx0[i] !== exp0[i]) begin errors++; $display("FAIL bp_order[%0d]: got %h want %h", i, rx0[i], exp0[i]); end
        end
        checks++;
        if (rx1.size() != 1 || rx1[0] !== 8'h04) begin errors++; $display("FAIL bp_rx1: got %0d beats want one 04", rx1.size()); end
        $display("test_backpressure: y0=%p y1=%p", rx0, rx1);
    endtask

    task automatic test_simultaneous();
        rx0.delete();
        bus.y0_ready = 1'b0;
        send(8'h66, 1'b0);
        checks++;
        if (bus.count0 !== 2'd1) begin errors++; $display("FAIL sim_pre_count: got %0d want 1", bus.count0); end
        bus.y0_ready = 1'b1;
        send(8'h55, 1'b0);
        checks++;
        if (bus.count0 !== 2'd1) begin errors++; $display("FAIL sim_count: got %0d want 1", bus.count0); end
        checks++;
        if (bus.y0_valid !== 1'b1 || bus.y0 !== 8'h55) begin
            errors++; $display("FAIL sim_head: got valid=%b y0=%h want 1/55", bus.y0_valid, bus.y0);
        end
        tick();
        checks++;
        if (rx0.size() != 2 || rx0[0] !== 8'h66 || rx0[1] !== 8'h55) begin
            errors++; $display("FAIL sim_rx: got %0d beats want 66,55", rx0.size());
        end
        $display("test_simultaneous: y0=%p", rx0);
    endtask

    task automatic test_wrap();
        bit done = 0;
        rx0.delete();
        bus.y0_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) send(W'(8'h10 + i), 1'b0);
            end
            begin
                repeat (40) begin
                    tick();
                    bus.y0_ready = 1'($urandom_range(0, 1));
                end
                bus.y0_ready = 1'b1;
            end
        join
        bus.y0_ready = 1'b1;
        for (int c = 0; c < 20 && !done; c++) begin
            tick();
            done = (rx0.size() >= 10);
        end
        checks++;
        if (rx0.size() != 10) begin errors++; $display("FAIL wrap_len: got %0d want 10", rx0.size()); end
        for (int i = 0; i < 10 && i < rx0.size(); i++) begin
            checks++;
            if (rx0[i] !== W'(8'h10 + i)) begin errors++; $display("FAIL wrap_order[%0d]: got %h want %h", i, rx0[i], 8'h10 + i); end
        end
        $display("test_wrap: y0=%p", rx0);
    endtask

    task automatic test_reset_mid();
        bus.y0_ready = 1'b0;
        bus.y1_ready = 1'b0;
        send(8'hA1, 1'b0);
        send(8'hA2, 1'b0);
        send(8'hB1, 1'b1);
        checks++;
        if (bus.count0 !== 2'd2 || bus.count1 !== 2'd1) begin
            errors++; $display("FAIL mid_pre: got counts %0d/%0d want 2/1", bus.count0, bus.count1);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.y0_valid !== 1'b0 || bus.y1_valid !== 1'b0) begin
            errors++; $display("FAIL mid_valids: got %b%b want 00", bus.y1_valid, bus.y0_valid);
        end
        checks++;
        if (bus.count0 !== '0 || bus.count1 !== '0 || bus.d_ready !== 1'b0) begin
            errors++; $display("FAIL mid_state: got counts %0d/%0d d_ready=%b want 0/0/0", bus.count0, bus.count1, bus.d_ready);
        end
        repeat (2) tick();
        reset_n = 1'b1;
        rx0.delete();
        rx1.delete();
        bus.y0_ready = 1'b1;
        bus.y1_ready = 1'b1;
        repeat (5) tick();
        checks++;
        if (rx0.size() != 0 || rx1.size() != 0 || bus.y0_valid !== 1'b0 || bus.y1_valid !== 1'b0) begin
            errors++; $display("FAIL mid_stale: got %0d/%0d beats valids=%b%b want none", rx0.size(), rx1.size(), bus.y1_valid, bus.y0_valid);
        end
        $display("test_reset_mid: done");
    endtask

    initial begin
        test_reset();
        test_basic_routing();
        test_backpressure();
        test_simultaneous();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
